// File: rtl/vga_pkg.sv
// Shared screen geometry, field widths and arbiter state encoding for the
// rectangle-fill path feeding the vga_adapter pixel port.
package vga_pkg;
  localparam int XSCREEN = 160;
  localparam int YSCREEN = 120;
  localparam int XW      = 8;
  localparam int YW      = 7;
  localparam int CW      = 3;
  localparam int SW      = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DRAW = 2'd2,
    DONE = 2'd3
  } state_t;
endpackage

// File: rtl/vga_rect_arbiter_if.sv
// Requester-side rectangle requests plus the shared VGA pixel port; the slave
// modport is the arbiter, the master modport is whoever drives the requests.
interface vga_rect_arbiter_if #(
  parameter int NREQ = 3
) ();
  import vga_pkg::*;

  logic [NREQ-1:0]    req;
  logic [XW*NREQ-1:0] req_x;
  logic [YW*NREQ-1:0] req_y;
  logic [SW*NREQ-1:0] req_w;
  logic [SW*NREQ-1:0] req_h;
  logic [CW*NREQ-1:0] req_colour;
  logic               stall;
  logic [NREQ-1:0]    gnt;
  logic [NREQ-1:0]    done;
  logic               busy;
  logic [XW-1:0]      vga_x;
  logic [YW-1:0]      vga_y;
  logic [CW-1:0]      vga_colour;
  logic               plot;

  modport master (
    output req, req_x, req_y, req_w, req_h, req_colour, stall,
    input  gnt, done, busy, vga_x, vga_y, vga_colour, plot
  );

  modport slave (
    input  req, req_x, req_y, req_w, req_h, req_colour, stall,
    output gnt, done, busy, vga_x, vga_y, vga_colour, plot
  );
endinterface

// File: rtl/rect_walker.sv
// Raster scan of a (w+1)x(h+1) rectangle: cx runs fastest, cy steps on cx wrap.
// Holds on the final pixel so the caller can still read the last coordinate.
module rect_walker
  import vga_pkg::*;
(
  input  logic          CLOCK_50,
  input  logic          Resetn,
  input  logic          load,
  input  logic          advance,
  input  logic [SW-1:0] w,
  input  logic [SW-1:0] h,
  output logic [SW-1:0] cx,
  output logic [SW-1:0] cy,
  output logic          last
);
  assign last = (cx == w) && (cy == h);

  always_ff @(posedge CLOCK_50) begin
    if (!Resetn) begin
      cx <= '0;
      cy <= '0;
    end else if (load) begin
      cx <= '0;
      cy <= '0;
    end else if (advance && !last) begin
      if (cx == w) begin
        cx <= '0;
        cy <= cy + 1'b1;
      end else begin
        cx <= cx + 1'b1;
      end
    end
  end
endmodule

// File: rtl/vga_rect_arbiter.sv
// Round-robin arbiter that fills one requester's rectangle at a time on the VGA
// pixel port; one pixel per unstalled DRAW cycle, stall freezes the scan.
module vga_rect_arbiter #(
  parameter int NREQ    = 3,
  parameter int XSCREEN = vga_pkg::XSCREEN,
  parameter int YSCREEN = vga_pkg::YSCREEN
) (
  input  logic           CLOCK_50,
  input  logic           Resetn,
  vga_rect_arbiter_if.slave bus
);
  import vga_pkg::XW, vga_pkg::YW, vga_pkg::CW, vga_pkg::SW;
  import vga_pkg::state_t, vga_pkg::IDLE, vga_pkg::LOAD, vga_pkg::DRAW, vga_pkg::DONE;

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [XW:0] XLIM = (XW+1)'(XSCREEN);
  localparam logic [YW:0] YLIM = (YW+1)'(YSCREEN);

  state_t        state, nxt;
  logic [IW-1:0] ptr, win, pick, cand;
  logic          found;
  logic [XW-1:0] x0;
  logic [YW-1:0] y0;
  logic [SW-1:0] w0, h0, cx, cy;
  logic [CW-1:0] col;
  logic          last, load, advance;
  logic [XW:0]   xs;
  logic [YW:0]   ys;

  // Search starts one past the last winner so every requester gets its turn.
  always_comb begin
    pick  = ptr;
    cand  = '0;
    found = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = IW'((int'(ptr) + k) % NREQ);
      if (!found && bus.req[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (!Resetn) state <= IDLE;
    else         state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (found) nxt = LOAD;
      LOAD:    nxt = DRAW;
      DRAW:    if (advance && last) nxt = DONE;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (!Resetn) begin
      ptr <= IW'(NREQ - 1);
      win <= '0;
      x0  <= '0;
      y0  <= '0;
      w0  <= '0;
      h0  <= '0;
      col <= '0;
    end else begin
      if (state == IDLE && found) win <= pick;
      if (state == LOAD) begin
        x0  <= bus.req_x[int'(win)*XW +: XW];
        y0  <= bus.req_y[int'(win)*YW +: YW];
        w0  <= bus.req_w[int'(win)*SW +: SW];
        h0  <= bus.req_h[int'(win)*SW +: SW];
        col <= bus.req_colour[int'(win)*CW +: CW];
      end
      if (state == DONE) ptr <= win;
    end
  end

  assign load    = (state == LOAD);
  assign advance = (state == DRAW) && !bus.stall;

  rect_walker u_walker (
    .CLOCK_50 (CLOCK_50),
    .Resetn   (Resetn),
    .load     (load),
    .advance  (advance),
    .w        (w0),
    .h        (h0),
    .cx       (cx),
    .cy       (cy),
    .last     (last)
  );

  // Widened sums so a rectangle hanging off the right/bottom edge never wraps.
  assign xs             = {1'b0, x0} + {{(XW+1-SW){1'b0}}, cx};
  assign ys             = {1'b0, y0} + {{(YW+1-SW){1'b0}}, cy};
  assign bus.plot       = advance && (xs < XLIM) && (ys < YLIM);
  assign bus.vga_x      = xs[XW-1:0];
  assign bus.vga_y      = ys[YW-1:0];
  assign bus.vga_colour = col;
  assign bus.busy       = (state != IDLE);

  always_comb begin
    bus.gnt  = '0;
    bus.done = '0;
    if (state == LOAD || state == DRAW) bus.gnt[win] = 1'b1;
    if (state == DONE)                  bus.done[win] = 1'b1;
  end
endmodule

// File: tb/tb_vga_rect_arbiter.sv
// Self-checking bench: vector table of single rectangles plus round-robin and
// reset-abort sequences; plotted pixels are scored against an expected queue.
module tb_vga_rect_arbiter;
  localparam int NREQ = 3;

  logic CLOCK_50 = 1'b0;
  logic Resetn   = 1'b0;
  always #10 CLOCK_50 = ~CLOCK_50;

  vga_rect_arbiter_if #(.NREQ(NREQ)) bus ();

  vga_rect_arbiter #(.NREQ(NREQ), .XSCREEN(160), .YSCREEN(120)) dut (
    .CLOCK_50 (CLOCK_50),
    .Resetn   (Resetn),
    .bus      (bus)
  );

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
  } pix_t;

  typedef struct {
    int         idx;
    int         x, y, w, h, col;
    int         st_at, st_len;
    logic [2:0] exp_gnt;
    int         exp_done;
    int         exp_pix;
  } vec_t;

  pix_t exp_q[$];
  vec_t vecs[6];
  int   n_vec = 0, n_err = 0, plot_cnt = 0;
  bit   mon_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  always @(negedge CLOCK_50) begin
    if (mon_en) begin
      check("gnt_onehot", 32'($countones(bus.gnt) <= 1), 32'd1);
      if (bus.plot === 1'b1) begin
        plot_cnt++;
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_plot: got pixel (%0d,%0d), expected none", bus.vga_x, bus.vga_y);
        end else begin
          check("pixel", {14'd0, bus.vga_x, bus.vga_y, bus.vga_colour}, {14'd0, exp_q.pop_front()});
        end
      end
    end
  end

  task automatic set_fields(input int i, input int x, input int y, input int w, input int h, input int c);
    bus.req_x[8*i +: 8]      = 8'(x);
    bus.req_y[7*i +: 7]      = 7'(y);
    bus.req_w[4*i +: 4]      = 4'(w);
    bus.req_h[4*i +: 4]      = 4'(h);
    bus.req_colour[3*i +: 3] = 3'(c);
  endtask

  // Expected on-screen pixels of a rectangle in raster order.
  task automatic push_rect(input int x, input int y, input int w, input int h, input int c);
    pix_t p;
    for (int yy = 0; yy <= h; yy++)
      for (int xx = 0; xx <= w; xx++)
        if (x + xx < 160 && y + yy < 120) begin
          p.x = 8'(x + xx);
          p.y = 7'(y + yy);
          p.c = 3'(c);
          exp_q.push_back(p);
        end
  endtask

  task automatic do_reset();
    Resetn    = 1'b0;
    bus.req   = '0;
    bus.stall = 1'b0;
    repeat (2) @(posedge CLOCK_50);
    #1;
    @(negedge CLOCK_50);
    check("rst_gnt", bus.gnt, 0);
    check("rst_done", bus.done, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_plot", bus.plot, 0);
    check("rst_vga_x", bus.vga_x, 0);
    check("rst_vga_y", bus.vga_y, 0);
    check("rst_colour", bus.vga_colour, 0);
    @(posedge CLOCK_50);
    #1;
    Resetn = 1'b1;
  endtask

  // Entered and left just after a rising edge with the arbiter idle.
  task automatic run_vec(input vec_t v);
    int dc, p0;
    dc = -1;
    p0 = plot_cnt;
    set_fields(v.idx, v.x, v.y, v.w, v.h, v.col);
    push_rect(v.x, v.y, v.w, v.h, v.col);
    bus.req        = '0;
    bus.req[v.idx] = 1'b1;
    for (int c = 1; c <= v.exp_done + 20; c++) begin
      @(posedge CLOCK_50);
      #1;
      bus.stall = (v.st_len > 0) && (c >= v.st_at) && (c < v.st_at + v.st_len);
      if (c == 1) bus.req = '0;
      @(negedge CLOCK_50);
      if (c == 1) check("gnt", bus.gnt, v.exp_gnt);
      if (bus.done != 0) begin
        dc = c;
        break;
      end
    end
    check("done_cycle", dc, v.exp_done);
    check("done_val", bus.done, v.exp_gnt);
    @(posedge CLOCK_50);
    #1;
    bus.stall = 1'b0;
    @(negedge CLOCK_50);
    check("done_one_cycle", bus.done, 0);
    check("busy_after", bus.busy, 0);
    check("plot_count", plot_cnt - p0, v.exp_pix);
    check("queue_drained", exp_q.size(), 0);
    @(posedge CLOCK_50);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [2:0] order [4];
    logic [2:0] pg, pd;
    int k, dc;

    //          idx  x    y    w   h  col at len gnt     done  pix
    vecs[0] = '{0,   10,  20,  1,  1, 5,  0, 0,  3'b001, 6,    4};
    vecs[1] = '{1,   158, 118, 3,  3, 2,  0, 0,  3'b010, 18,   4};
    vecs[2] = '{2,   0,   0,   3,  0, 7,  4, 5,  3'b100, 11,   4};
    vecs[3] = '{1,   159, 119, 15, 15, 1, 0, 0,  3'b010, 258,  1};
    vecs[4] = '{0,   0,   0,   0,  0, 3,  0, 0,  3'b001, 3,    1};
    vecs[5] = '{2,   255, 127, 0,  0, 4,  0, 0,  3'b100, 3,    0};

    bus.req_x = '0; bus.req_y = '0; bus.req_w = '0; bus.req_h = '0; bus.req_colour = '0;
    do_reset();
    mon_en = 1'b1;

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // Three simultaneous held requests: service order 0,1,2,0 after reset.
    do_reset();
    order = '{3'b001, 3'b010, 3'b100, 3'b001};
    for (int i = 0; i < NREQ; i++) set_fields(i, 10 * i + 1, 5, 0, 0, i + 1);
    push_rect(1, 5, 0, 0, 1);
    push_rect(11, 5, 0, 0, 2);
    push_rect(21, 5, 0, 0, 3);
    push_rect(1, 5, 0, 0, 1);
    bus.req = 3'b111;
    k  = 0;
    pg = '0;
    pd = '0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge CLOCK_50);
      #1;
      if (k >= 4) bus.req = '0;
      @(negedge CLOCK_50);
      if (bus.gnt != 0 && pg == 0) begin
        if (k < 4) check("rr_gnt", bus.gnt, order[k]);
        k++;
      end
      if (bus.done != 0) check("rr_done_width", pd, 0);
      pg = bus.gnt;
      pd = bus.done;
      if (k >= 4 && bus.busy == 1'b0) break;
    end
    check("rr_services", k, 4);
    check("rr_queue_drained", exp_q.size(), 0);
    @(posedge CLOCK_50);
    #1;

    // Reset in the middle of a 16x16 fill, request still held.
    mon_en = 1'b0;
    set_fields(1, 20, 30, 15, 15, 6);
    bus.req = 3'b010;
    repeat (10) @(posedge CLOCK_50);
    #1;
    @(negedge CLOCK_50);
    check("abort_pre_busy", bus.busy, 1);
    @(posedge CLOCK_50);
    #1;
    Resetn = 1'b0;
    @(posedge CLOCK_50);
    #1;
    @(negedge CLOCK_50);
    check("abort_gnt", bus.gnt, 0);
    check("abort_done", bus.done, 0);
    check("abort_busy", bus.busy, 0);
    check("abort_plot", bus.plot, 0);
    check("abort_xyc", {bus.vga_x, bus.vga_y, bus.vga_colour}, 0);
    @(posedge CLOCK_50);
    #1;
    Resetn = 1'b1;
    dc = -1;
    for (int c = 1; c <= 300; c++) begin
      @(posedge CLOCK_50);
      #1;
      if (c == 1) bus.req = '0;
      @(negedge CLOCK_50);
      if (c == 1) check("restart_gnt", bus.gnt, 3'b010);
      if (c == 2) begin
        check("restart_plot", bus.plot, 1);
        check("restart_x", bus.vga_x, 20);
        check("restart_y", bus.vga_y, 30);
        check("restart_colour", bus.vga_colour, 6);
      end
      if (bus.done != 0) begin
        dc = c;
        break;
      end
    end
    check("restart_done_cycle", dc, 258);
    check("restart_done_val", bus.done, 3'b010);
    @(posedge CLOCK_50);
    #1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
